// File: rtl/pkt_input_arbiter.sv
// Round-robin arbiter that serializes whole packets from two byte sources onto one output.
// Optional length check enabled by defining PKT_ARB_LEN_CHECK_EN.
module pkt_input_arbiter #(
    parameter int GAP_CYCLES = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [7:0]           src0_data,
    input  logic                 src0_valid,
    input  logic                 src0_last,
    output logic                 src0_ready,
    input  logic [7:0]           src1_data,
    input  logic                 src1_valid,
    input  logic                 src1_last,
    output logic                 src1_ready,
    output logic [7:0]           dataout_data,
    output logic                 dataout_valid,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic                 underrun_err,
    input  logic                 err_clr,
    output logic [CNT_WIDTH-1:0] pkt_cnt0,
    output logic [CNT_WIDTH-1:0] pkt_cnt1,
    output logic                 len_err,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, FLUSH = 2'd2, GAP = 2'd3} state_t;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    state_t        state, state_nx;
    logic [GW-1:0] gap_cnt;
    logic          rr_last;
    logic          pick;
    logic          sel_valid, sel_last;
    logic [7:0]    sel_data;
    logic          xfer_acc, flush_end, underrun;

    // Handshake: a byte moves on a cycle where the granted source has valid=1 and ready=1.
    // Ready is asserted only to the granted source, only in XFER and FLUSH.
    assign src0_ready = ((state == XFER) || (state == FLUSH)) && grant[0];
    assign src1_ready = ((state == XFER) || (state == FLUSH)) && grant[1];

    assign sel_valid = grant[1] ? src1_valid : src0_valid;
    assign sel_last  = grant[1] ? src1_last  : src0_last;
    assign sel_data  = grant[1] ? src1_data  : src0_data;

    assign xfer_acc  = (state == XFER) && sel_valid;
    assign underrun  = (state == XFER) && !sel_valid;
    assign flush_end = (state == FLUSH) && sel_valid && sel_last;

    // rr_last holds the index granted most recently; a tie goes to the other one.
    assign pick = (src0_valid && src1_valid) ? ~rr_last : src1_valid;

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (enable && (src0_valid || src1_valid)) state_nx = XFER;
            XFER:  if (!sel_valid) state_nx = FLUSH;
                   else if (sel_last) state_nx = GAP;
            FLUSH: if (sel_valid && sel_last) state_nx = GAP;
            GAP:   if (gap_cnt == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= 2'b00;
            rr_last       <= 1'b1;
            gap_cnt       <= '0;
            dataout_data  <= 8'h00;
            dataout_valid <= 1'b0;
            underrun_err  <= 1'b0;
            pkt_cnt0      <= '0;
            pkt_cnt1      <= '0;
        end else begin
            state         <= state_nx;
            dataout_valid <= 1'b0;
            dataout_data  <= 8'h00;
            underrun_err  <= underrun | (underrun_err & ~err_clr);
            case (state)
                IDLE: begin
                    if (enable && (src0_valid || src1_valid)) begin
                        grant   <= pick ? 2'b10 : 2'b01;
                        rr_last <= pick;
                    end
                end
                XFER: begin
                    if (sel_valid) begin
                        dataout_valid <= 1'b1;
                        dataout_data  <= sel_data;
                        if (sel_last) begin
                            gap_cnt <= GAP_LOAD;
                            if (grant[1]) pkt_cnt1 <= pkt_cnt1 + 1'b1;
                            else          pkt_cnt0 <= pkt_cnt0 + 1'b1;
                        end
                    end
                end
                FLUSH: if (flush_end) gap_cnt <= GAP_LOAD;
                GAP: begin
                    if (gap_cnt == '0) grant <= 2'b00;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PKT_ARB_LEN_CHECK_EN
    logic [8:0] byte_cnt;
    logic [7:0] len_q;
    logic [7:0] eff_len;
    logic       len_set;

    // The length byte may itself be the last byte, so use it directly in that case.
    always_comb begin
        eff_len = (byte_cnt == 9'd1) ? sel_data : len_q;
        len_set = 1'b0;
        if (xfer_acc && sel_last)
            len_set = (byte_cnt == 9'd0) ||
                      (({1'b0, byte_cnt} + 10'd1) != ({2'b00, eff_len} + 10'd2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            len_q    <= 8'h00;
            len_err  <= 1'b0;
        end else begin
            len_err <= len_set | (len_err & ~err_clr);
            if (state == IDLE) begin
                byte_cnt <= '0;
            end else if (xfer_acc) begin
                if (byte_cnt != '1) byte_cnt <= byte_cnt + 9'd1;
                if (byte_cnt == 9'd1) len_q <= sel_data;
            end
        end
    end
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_pkt_input_arbiter.sv
// Directed bench for pkt_input_arbiter: single packet, round-robin, underrun, enable, reset, length.
module tb_pkt_input_arbiter;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic [7:0]    src0_data = 8'h00, src1_data = 8'h00;
    logic          src0_valid = 1'b0, src1_valid = 1'b0;
    logic          src0_last = 1'b0, src1_last = 1'b0;
    logic          src0_ready, src1_ready;
    logic [7:0]    dataout_data;
    logic          dataout_valid;
    logic [1:0]    grant;
    logic          busy, underrun_err, len_err;
    logic          err_clr = 1'b0;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;
    logic [1:0]    state_dbg;

    pkt_input_arbiter #(.GAP_CYCLES(2), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .src0_data(src0_data), .src0_valid(src0_valid), .src0_last(src0_last), .src0_ready(src0_ready),
        .src1_data(src1_data), .src1_valid(src1_valid), .src1_last(src1_last), .src1_ready(src1_ready),
        .dataout_data(dataout_data), .dataout_valid(dataout_valid), .grant(grant), .busy(busy),
        .underrun_err(underrun_err), .err_clr(err_clr), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
        .len_err(len_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_q[$];
    int         gap_q[$];
    logic [1:0] grant_q[$];
    logic       seen_hi = 1'b0;
    int         low_run = 0;
    logic [1:0] prev_grant = 2'b00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (dataout_valid) begin
            mon_q.push_back(dataout_data);
            if (seen_hi && low_run > 0) gap_q.push_back(low_run);
            seen_hi = 1'b1;
            low_run = 0;
        end else if (seen_hi) begin
            low_run++;
        end
        if (grant != 2'b00 && prev_grant == 2'b00) grant_q.push_back(grant);
        prev_grant = grant;
    end

    task automatic clear_mon();
        mon_q.delete(); gap_q.delete(); grant_q.delete(); exp_q.delete();
        seen_hi = 1'b0; low_run = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic drive(input int s, input logic v, input logic [7:0] d, input logic l);
        if (s == 0) begin src0_valid = v; src0_data = d; src0_last = l; end
        else        begin src1_valid = v; src1_data = d; src1_last = l; end
    endtask

    function automatic logic rdy(input int s);
        return (s == 0) ? src0_ready : src1_ready;
    endfunction

    // Called on a falling edge; returns on the falling edge after the final byte is taken.
    task automatic send(input int s, input logic [7:0] pk[$], input logic with_last);
        for (int i = 0; i < pk.size(); i++) begin
            int n;
            logic acc;
            n = 0;
            drive(s, 1'b1, pk[i], with_last && (i == pk.size() - 1));
            forever begin
                acc = rdy(s);
                @(negedge clk);
                if (acc) break;
                n++;
                if (n > 200) begin
                    check("send_timeout", 32'(n), 32'd0);
                    break;
                end
            end
        end
        drive(s, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic cmp_stream(input string tag);
        check({tag, "_len"}, 32'(mon_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
            check(tag, {24'h0, mon_q[i]}, {24'h0, exp_q[i]});
    endtask

    logic [7:0] pa[$], pb[$], pc[$], pd[$], pe[$], pf[$];

    initial begin
        @(negedge clk);
        do_reset();
        // reset state
        check("rst_valid", {31'h0, dataout_valid}, 32'd0);
        check("rst_data", {24'h0, dataout_data}, 32'd0);
        check("rst_grant", {30'h0, grant}, 32'd0);
        check("rst_state", {30'h0, state_dbg}, 32'd0);
        check("rst_cnt0", {30'h0, pkt_cnt0}, 32'd0);
        check("rst_uerr", {31'h0, underrun_err}, 32'd0);
        check("rst_ready", {30'h0, src1_ready, src0_ready}, 32'd0);

        // single packet with latency
        pa = {8'h12, 8'h03, 8'hA0, 8'hA1, 8'hA2};
        fork
            send(0, pa, 1'b1);
            begin
                @(negedge clk);
                check("t1_grant", {30'h0, grant}, 32'd1);
                check("t1_lat_v0", {31'h0, dataout_valid}, 32'd0);
                check("t1_ready1", {31'h0, src1_ready}, 32'd0);
                @(negedge clk);
                check("t1_lat_v1", {31'h0, dataout_valid}, 32'd1);
                check("t1_first", {24'h0, dataout_data}, 32'h12);
            end
        join
        repeat (5) @(negedge clk);
        exp_q = {8'h12, 8'h03, 8'hA0, 8'hA1, 8'hA2};
        cmp_stream("t1_data");
        check("t1_nogap", 32'(gap_q.size()), 32'd0);
        check("t1_cnt0", {30'h0, pkt_cnt0}, 32'd1);
        check("t1_cnt1", {30'h0, pkt_cnt1}, 32'd0);
        check("t1_idle", {31'h0, busy}, 32'd0);
        check("t1_lenerr", {31'h0, len_err}, 32'd0);

        // both sources contend from reset: alternation and idle gaps
        rst = 1'b1;
        pa = {8'h10, 8'h11, 8'h12}; pb = {8'h20, 8'h21, 8'h22}; pc = {8'h30, 8'h31, 8'h32};
        pd = {8'h40, 8'h41}; pe = {8'h50, 8'h51, 8'h52, 8'h53}; pf = {8'h60};
        fork
            begin repeat (2) @(negedge clk); rst = 1'b0; clear_mon(); end
            begin send(0, pa, 1'b1); send(0, pb, 1'b1); send(0, pc, 1'b1); end
            begin send(1, pd, 1'b1); send(1, pe, 1'b1); send(1, pf, 1'b1); end
        join
        repeat (5) @(negedge clk);
        exp_q = {8'h10, 8'h11, 8'h12, 8'h40, 8'h41, 8'h20, 8'h21, 8'h22,
                 8'h50, 8'h51, 8'h52, 8'h53, 8'h30, 8'h31, 8'h32, 8'h60};
        cmp_stream("t2_data");
        check("t2_ngrant", 32'(grant_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_q.size(); i++)
            check("t2_grant", {30'h0, grant_q[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
        check("t2_ngap", 32'(gap_q.size()), 32'd5);
        for (int i = 0; i < gap_q.size(); i++)
            check("t2_gap", 32'(gap_q[i]), 32'd3);
        check("t2_cnt0", {30'h0, pkt_cnt0}, 32'd3);
        check("t2_cnt1", {30'h0, pkt_cnt1}, 32'd3);
        pa = {8'h70};
        send(0, pa, 1'b1);
        repeat (4) @(negedge clk);
        check("t2_wrap0", {30'h0, pkt_cnt0}, 32'd0);

        // underrun on src1 after two bytes
        do_reset();
        pa = {8'hC0, 8'hC1};
        send(1, pa, 1'b0);
        check("t3_pre_v", {31'h0, dataout_valid}, 32'd1);
        @(negedge clk);
        check("t3_drop_v", {31'h0, dataout_valid}, 32'd0);
        check("t3_uerr", {31'h0, underrun_err}, 32'd1);
        check("t3_state", {30'h0, state_dbg}, 32'd2);
        repeat (2) @(negedge clk);
        pb = {8'hC2, 8'hC3};
        send(1, pb, 1'b1);
        repeat (5) @(negedge clk);
        exp_q = {8'hC0, 8'hC1};
        cmp_stream("t3_data");
        check("t3_cnt1", {30'h0, pkt_cnt1}, 32'd0);
        check("t3_idle", {31'h0, busy}, 32'd0);
        check("t3_sticky", {31'h0, underrun_err}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t3_clr", {31'h0, underrun_err}, 32'd0);

        // enable dropped mid-packet with src1 waiting
        do_reset();
        pa = {8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
        pb = {8'hE0, 8'hE1};
        fork
            send(0, pa, 1'b1);
            begin repeat (3) @(negedge clk); enable = 1'b0; send(1, pb, 1'b1); end
        join_none
        repeat (14) @(negedge clk);
        check("t4_cnt0", {30'h0, pkt_cnt0}, 32'd1);
        check("t4_grant", {30'h0, grant}, 32'd0);
        check("t4_busy", {31'h0, busy}, 32'd0);
        check("t4_cnt1", {30'h0, pkt_cnt1}, 32'd0);
        enable = 1'b1;
        wait fork;
        repeat (5) @(negedge clk);
        check("t4_cnt1b", {30'h0, pkt_cnt1}, 32'd1);
        exp_q = {8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hE0, 8'hE1};
        cmp_stream("t4_data");

        // reset mid-packet
        drive(0, 1'b1, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        check("t5_pre_v", {31'h0, dataout_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        check("t5_valid", {31'h0, dataout_valid}, 32'd0);
        check("t5_grant", {30'h0, grant}, 32'd0);
        check("t5_cnt0", {30'h0, pkt_cnt0}, 32'd0);
        check("t5_cnt1", {30'h0, pkt_cnt1}, 32'd0);
        check("t5_state", {30'h0, state_dbg}, 32'd0);
        repeat (2) @(negedge clk);

`ifdef PKT_ARB_LEN_CHECK_EN
        do_reset();
        pa = {8'h01, 8'h04, 8'hB0, 8'hB1};
        send(0, pa, 1'b1);
        repeat (4) @(negedge clk);
        check("t6_bad", {31'h0, len_err}, 32'd1);
        check("t6_cnt", {30'h0, pkt_cnt0}, 32'd1);
        pb = {8'h01, 8'h01, 8'hB0};
        send(0, pb, 1'b1);
        repeat (4) @(negedge clk);
        check("t6_hold", {31'h0, len_err}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t6_clr", {31'h0, len_err}, 32'd0);
        send(0, pb, 1'b1);
        repeat (4) @(negedge clk);
        check("t6_good", {31'h0, len_err}, 32'd0);
        exp_q = {8'h01, 8'h04, 8'hB0, 8'hB1, 8'h01, 8'h01, 8'hB0, 8'h01, 8'h01, 8'hB0};
        cmp_stream("t6_data");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
